mult_div_unit: RTL and testbench

//  E-stage multiply/divide unit with HI/LO registers. It raises the Busy signal that the

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit_md_arith.sv | 74 +++++++
 rtl/mult_div_unit.sv | 109 ++++++++++
 tb/tb_mult_div_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// default latencies and small decode helpers.
package mult_div_unit_pkg;

  // Operation encodings presented on MDOp; 0 and 7 are not operations.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Default cycle counts for which Busy stays high after an accept.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // True for any encoding that the unit will accept.
  function automatic logic md_op_valid(input logic [2:0] op);
    logic ok;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational arithmetic core of the multiply/divide unit. Produces the
// HI/LO pair an operation will eventually commit, including the
// divide-by-zero and signed-overflow corner cases.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_n_o,
  output logic [31:0] lo_n_o
);

  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic signed [31:0] sdiv_q_s;
  logic signed [31:0] sdiv_r_s;
  logic        [31:0] udiv_q_s;
  logic        [31:0] udiv_r_s;
  logic               b_zero_s;
  logic               s_ovf_s;

  // Raw products and quotients; the corner cases are selected below.
  assign smul_s   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign umul_s   = {32'd0, a_i} * {32'd0, b_i};
  assign sdiv_q_s = $signed(a_i) / $signed(b_i);
  assign sdiv_r_s = $signed(a_i) % $signed(b_i);
  assign udiv_q_s = a_i / b_i;
  assign udiv_r_s = a_i % b_i;
  assign b_zero_s = (b_i == 32'd0);
  assign s_ovf_s  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Select the result pair for the requested operation.
  always_comb begin
    hi_n_o = 32'd0;
    lo_n_o = 32'd0;
    case (md_op_i)
      MD_MULT: begin
        hi_n_o = smul_s[63:32];
        lo_n_o = smul_s[31:0];
      end
      MD_MULTU: begin
        hi_n_o = umul_s[63:32];
        lo_n_o = umul_s[31:0];
      end
      MD_DIV: begin
        if (b_zero_s) begin
          hi_n_o = a_i;
          lo_n_o = 32'hFFFF_FFFF;
        end else if (s_ovf_s) begin
          hi_n_o = 32'd0;
          lo_n_o = 32'h8000_0000;
        end else begin
          hi_n_o = sdiv_r_s;
          lo_n_o = sdiv_q_s;
        end
      end
      MD_DIVU: begin
        if (b_zero_s) begin
          hi_n_o = a_i;
          lo_n_o = 32'hFFFF_FFFF;
        end else begin
          hi_n_o = udiv_r_s;
          lo_n_o = udiv_q_s;
        end
      end
      default: begin
        hi_n_o = 32'd0;
        lo_n_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// Mult/div results are computed at accept time into pending registers and
// committed after a fixed latency; Busy covers that window so the hazard
// logic can stall further MD operations.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_n_s, lo_n_s;
  logic             accept_s;

  md_arith u_md_arith (
    .md_op_i (MDOp),
    .a_i     (A),
    .b_i     (B),
    .hi_n_o  (hi_n_s),
    .lo_n_o  (lo_n_s)
  );

  // A request is taken only while idle and only for a real operation.
  assign accept_s = Start & ~busy_q & md_op_valid(MDOp);

  // Next-state: accept, latency countdown, and the commit on the final count.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (accept_s) begin
      case (MDOp)
        MD_MULT, MD_MULTU: begin
          cnt_d     = CNT_MULT;
          pend_hi_d = hi_n_s;
          pend_lo_d = lo_n_s;
        end
        MD_DIV, MD_DIVU: begin
          cnt_d     = CNT_DIV;
          pend_hi_d = hi_n_s;
          pend_lo_d = lo_n_s;
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: cnt_d = cnt_q;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != '0);
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and
// latency per accepted op; an independent monitor pops on each commit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        scb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: what HI/LO become after op, and its Busy length.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, inout logic [31:0] hi,
                                    inout logic [31:0] lo, output int lat);
    longint      sa, sv, q, r;
    logic [63:0] p;
    lat = 0;
    sa  = longint'($signed(a));
    sv  = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sv; hi = p[63:32]; lo = p[31:0]; lat = MULT_LAT; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; lat = MULT_LAT; end
      3'd3: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin
          q = ((sa < 0) ? -sa : sa) / ((sv < 0) ? -sv : sv);
          if ((sa < 0) != (sv < 0)) q = -q;
          r = sa - q * sv;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      3'd4: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin
          q = longint'(a) / longint'(b);
          r = longint'(a) - q * longint'(b);
          lo = q[31:0]; hi = r[31:0];
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: lat = 0;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (Busy !== 1'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: Busy=%b still set after %0d cycles, required 0", Busy, n);
    end
  endtask

  // Issue one request at a negedge; optionally poke a Start during Busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit bogus);
    int          lat;
    logic [31:0] h, l;
    wait_idle();
    Start = 1'b1; MDOp = op; A = a; B = b;
    h = mdl_hi; l = mdl_lo;
    ref_model(op, a, b, h, l, lat);
    if (op >= 3'd1 && op <= 3'd6) begin
      scb.push_back('{h, l, lat});
      mdl_hi = h;
      mdl_lo = l;
    end
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
    chk("busy_after_issue", {31'd0, Busy}, (lat > 0) ? 32'd1 : 32'd0);
    if (bogus && lat > 0) begin
      Start = 1'b1; MDOp = MD_MULT; A = $urandom; B = $urandom;
      @(negedge clk);
      Start = 1'b0; MDOp = 3'd0;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT exposes a new HI/LO.
  logic [31:0] arch_hi = 32'd0, arch_lo = 32'd0;
  int          bcnt = 0;
  bit          prev_busy = 1'b0, mt_pend = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        arch_hi = 32'd0; arch_lo = 32'd0; bcnt = 0; prev_busy = 1'b0; mt_pend = 1'b0;
      end else begin
        if (mt_pend) begin
          mt_pend = 1'b0;
          if (scb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_mt: HI=%h LO=%h with no op expected", HI, LO);
          end else begin
            e = scb.pop_front();
            chk("mt_hi", HI, e.hi);
            chk("mt_lo", LO, e.lo);
            chk("mt_busy", {31'd0, Busy}, 32'd0);
            arch_hi = e.hi; arch_lo = e.lo;
          end
        end
        if (Busy === 1'b1) begin
          bcnt++;
          chk("hold_hi", HI, arch_hi);
          chk("hold_lo", LO, arch_lo);
        end else if (prev_busy) begin
          if (scb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_commit: HI=%h LO=%h with no op expected", HI, LO);
          end else begin
            e = scb.pop_front();
            chk("busy_len", 32'(bcnt), 32'(e.lat));
            chk("res_hi", HI, e.hi);
            chk("res_lo", LO, e.lo);
            arch_hi = e.hi; arch_lo = e.lo;
          end
          bcnt = 0;
        end
        prev_busy = (Busy === 1'b1);
        if (Start && !Busy && (MDOp == MD_MTHI || MDOp == MD_MTLO)) mt_pend = 1'b1;
      end
    end
  end

  // Stimulus: directed scenarios then randomized traffic.
  initial begin
    reset = 1'b0; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b1;

    issue(MD_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(MD_DIVU,  32'd7, 32'd0, 1'b0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(MD_MTLO,  32'h1234_5678, 32'd0, 1'b0);
    issue(MD_MTHI,  32'hCAFE_F00D, 32'd0, 1'b0);
    issue(MD_DIV,   32'd100, 32'd7, 1'b1);
    issue(3'd7,     32'd5, 32'd5, 1'b0);

    issue(MD_MULT, 32'd1234, 32'd5678, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    scb.delete();
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    issue(MD_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b0);

    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(MD_DIV,  32'hFFFF_FF00, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(scb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
